// File: rtl/aud_i2s_tx.sv
// I2S transmitter: serializes a DATA_W-bit sample MSB-first to the codec DAC pin, BCLK/LRCK oversampled on i_clk.
// Optional feature macro AUD_TX_STEREO_DUP_EN: repeat the left sample in the right slot (default: right slot is 0).
module aud_i2s_tx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_bclk,
  input  logic              i_daclrck,
  input  logic [DATA_W-1:0] i_dac_data,
  output logic              o_aud_dacdat,
  output logic              o_sample_req,
  output logic              o_busy,
  output logic [2:0]        o_dbg_state
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_DELAY = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic                   bclk_s;
  logic                   lrck_s;
  logic                   bclk_d;
  logic                   lrck_p;
  logic                   fall_ev;
  logic                   lrck_edge;
  logic                   left_start;
  logic                   dup_start;
  logic [DATA_W-1:0]      shreg;
  logic [CNT_W-1:0]       bit_cnt;
  logic [IDX_W-1:0]       bit_idx;

  assign bclk_s      = bclk_sync[SYNC_STAGES-1];
  assign lrck_s      = lrck_sync[SYNC_STAGES-1];
  assign fall_ev     = bclk_d & ~bclk_s;
  assign lrck_edge   = fall_ev & (lrck_p ^ lrck_s);
  assign left_start  = fall_ev & lrck_p & ~lrck_s;
  assign bit_idx     = IDX_W'(DATA_W - 1) - bit_cnt[IDX_W-1:0];
  assign o_dbg_state = state;

`ifdef AUD_TX_STEREO_DUP_EN
  assign dup_start = fall_ev & ~lrck_p & lrck_s;
`else
  assign dup_start = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_d    <= 1'b0;
      lrck_p    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i_bclk};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], i_daclrck};
      bclk_d    <= bclk_s;
      if (fall_ev) lrck_p <= lrck_s;
    end
  end

  // A slot boundary that lands while the LSB is due is the normal back-to-back case:
  // the LSB still goes out and the next slot's delay bit overlaps it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      o_aud_dacdat <= 1'b0;
      o_sample_req <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_sample_req <= 1'b0;
      if (!i_en) begin
        state        <= S_IDLE;
        bit_cnt      <= '0;
        o_aud_dacdat <= 1'b0;
        o_busy       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            o_aud_dacdat <= 1'b0;
            o_busy       <= 1'b0;
            state        <= S_WAIT;
          end
          S_WAIT, S_DONE: begin
            if (fall_ev) begin
              o_aud_dacdat <= 1'b0;
              o_busy       <= 1'b0;
            end
            if (left_start) begin
              shreg        <= i_dac_data;
              o_sample_req <= 1'b1;
              state        <= S_DELAY;
            end else if (dup_start && state == S_DONE) begin
              state <= S_DELAY;
            end
          end
          S_DELAY: begin
            if (fall_ev) begin
              if (lrck_edge) begin
                o_aud_dacdat <= 1'b0;
                o_busy       <= 1'b0;
                bit_cnt      <= '0;
                if (left_start) begin
                  shreg        <= i_dac_data;
                  o_sample_req <= 1'b1;
                  state        <= S_DELAY;
                end else begin
                  state <= S_DONE;
                end
              end else begin
                o_aud_dacdat <= shreg[DATA_W-1];
                o_busy       <= 1'b1;
                bit_cnt      <= CNT_W'(1);
                state        <= S_SEND;
              end
            end
          end
          S_SEND: begin
            if (fall_ev) begin
              if ((lrck_edge && bit_cnt < LAST_CNT) || bit_cnt == FULL_CNT) begin
                // Word finished, or frame cut short: stop driving and look for the next slot.
                o_aud_dacdat <= 1'b0;
                o_busy       <= 1'b0;
                bit_cnt      <= '0;
                if (left_start) begin
                  shreg        <= i_dac_data;
                  o_sample_req <= 1'b1;
                  state        <= S_DELAY;
                end else if (dup_start && bit_cnt == FULL_CNT) begin
                  state <= S_DELAY;
                end else begin
                  state <= S_DONE;
                end
              end else begin
                o_aud_dacdat <= shreg[bit_idx];
                bit_cnt      <= bit_cnt + 1'b1;
                if (left_start) begin
                  shreg        <= i_dac_data;
                  o_sample_req <= 1'b1;
                  state        <= S_DELAY;
                end else if (dup_start) begin
                  state <= S_DELAY;
                end else if (lrck_edge) begin
                  state <= S_DONE;
                end
              end
            end
          end
          default: begin
            state        <= S_IDLE;
            o_aud_dacdat <= 1'b0;
            o_busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aud_i2s_tx.sv
// Directed bench for aud_i2s_tx: BCLK/LRCK are driven as data (BCLK = i_clk/8), one DACDAT bit sampled per BCLK.
`timescale 1ns/1ps
module tb_aud_i2s_tx;
  localparam int W = 16;
`ifdef AUD_TX_STEREO_DUP_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_en;
  logic         i_bclk;
  logic         i_daclrck;
  logic [W-1:0] i_dac_data;
  logic         o_aud_dacdat;
  logic         o_sample_req;
  logic         o_busy;
  logic [2:0]   o_dbg_state;

  int n_tests = 0;
  int n_fail = 0;
  int req_total = 0;
  int sidx = 0;
  logic dat_s [0:4095];
  logic busy_s [0:4095];
  logic [W-1:0] exp_q[$];

  aud_i2s_tx #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
    .i_bclk       (i_bclk),
    .i_daclrck    (i_daclrck),
    .i_dac_data   (i_dac_data),
    .o_aud_dacdat (o_aud_dacdat),
    .o_sample_req (o_sample_req),
    .o_busy       (o_busy),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (o_sample_req === 1'b1) req_total++;

  task automatic do_reset();
    i_rst_n    = 1'b0;
    i_en       = 1'b0;
    i_bclk     = 1'b1;
    i_daclrck  = 1'b1;
    i_dac_data = '0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    sidx    = 0;
    @(negedge i_clk);
  endtask

  // driver: one BCLK period; LRCK changes with the falling BCLK edge
  task automatic tick(input logic lrck);
    @(negedge i_clk);
    i_bclk    = 1'b0;
    i_daclrck = lrck;
    repeat (4) @(negedge i_clk);
    dat_s[sidx]  = o_aud_dacdat;
    busy_s[sidx] = o_busy;
    sidx++;
    i_bclk = 1'b1;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic run_frame(input int left_len, input int right_len, input logic [W-1:0] next_data);
    for (int i = 0; i < left_len; i++) tick(1'b0);
    for (int i = 0; i < right_len; i++) begin
      if (i == right_len / 2) i_dac_data = next_data;
      tick(1'b1);
    end
  endtask

  function automatic logic [W-1:0] word_at(input int idx, input bit use_busy);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) w[W-1-i] = use_busy ? busy_s[idx+i] : dat_s[idx+i];
    return w;
  endfunction

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (o_aud_dacdat !== 1'b0) begin n_fail++; $display("FAIL reset_dacdat: got %b want 0", o_aud_dacdat); end
    n_tests++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_tests++;
    if (o_sample_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", o_sample_req); end
    n_tests++;
    if (o_dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", o_dbg_state); end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    i_en = 1'b1;
    i_dac_data = 16'hA5C3;
    tick(1'b1); tick(1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0);
    n_tests++;
    if (o_dbg_state !== 3'd3) begin n_fail++; $display("FAIL midsend_state: got %0d want 3", o_dbg_state); end
    n_tests++;
    if (o_aud_dacdat !== 1'b1 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL midsend_bit: got dat=%b busy=%b want 1/1", o_aud_dacdat, o_busy);
    end
    i_rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_aud_dacdat !== 1'b0 || o_busy !== 1'b0 || o_sample_req !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_out: got dat=%b busy=%b req=%b want 0/0/0", o_aud_dacdat, o_busy, o_sample_req);
    end
    n_tests++;
    if (o_dbg_state !== 3'd0) begin n_fail++; $display("FAIL async_reset_state: got %0d want 0", o_dbg_state); end
  endtask

  task automatic test_mono_frames();
    int s0, r0;
    logic [W-1:0] exp_r;
    do_reset();
    i_en = 1'b1;
    i_dac_data = 16'hA5C3;
    tick(1'b1); tick(1'b1);
    r0 = req_total;
    s0 = sidx;
    for (int f = 0; f < 3; f++) run_frame(16, 16, 16'hA5C3);
    tick(1'b1);
    exp_r = DUP ? 16'hA5C3 : 16'h0000;
    n_tests++;
    if (dat_s[s0] !== 1'b0) begin n_fail++; $display("FAIL delay_bit: got %b want 0", dat_s[s0]); end
    for (int f = 0; f < 3; f++) begin
      n_tests++;
      if (word_at(s0 + 32*f + 1, 1'b0) !== 16'hA5C3) begin
        n_fail++; $display("FAIL a5c3_left[%0d]: got %h want a5c3", f, word_at(s0 + 32*f + 1, 1'b0));
      end
      n_tests++;
      if (word_at(s0 + 32*f + 17, 1'b0) !== exp_r) begin
        n_fail++; $display("FAIL a5c3_right[%0d]: got %h want %h", f, word_at(s0 + 32*f + 17, 1'b0), exp_r);
      end
    end
    n_tests++;
    if (word_at(s0 + 1, 1'b1) !== 16'hFFFF) begin
      n_fail++; $display("FAIL busy_left: got %h want ffff", word_at(s0 + 1, 1'b1));
    end
    n_tests++;
    if (word_at(s0 + 17, 1'b1) !== (DUP ? 16'hFFFF : 16'h0000)) begin
      n_fail++; $display("FAIL busy_right: got %h want %h", word_at(s0 + 17, 1'b1), DUP ? 16'hFFFF : 16'h0000);
    end
    n_tests++;
    if (req_total - r0 != 3) begin n_fail++; $display("FAIL a5c3_req_count: got %0d want 3", req_total - r0); end
  endtask

  task automatic test_stereo_dup();
    int s0, r0;
    logic [W-1:0] exp_r;
    do_reset();
    i_en = 1'b1;
    i_dac_data = 16'h8001;
    tick(1'b1); tick(1'b1);
    r0 = req_total;
    s0 = sidx;
    for (int f = 0; f < 2; f++) run_frame(16, 16, 16'h8001);
    tick(1'b1);
    exp_r = DUP ? 16'h8001 : 16'h0000;
    for (int f = 0; f < 2; f++) begin
      n_tests++;
      if (word_at(s0 + 32*f + 1, 1'b0) !== 16'h8001) begin
        n_fail++; $display("FAIL 8001_left[%0d]: got %h want 8001", f, word_at(s0 + 32*f + 1, 1'b0));
      end
      n_tests++;
      if (word_at(s0 + 32*f + 17, 1'b0) !== exp_r) begin
        n_fail++; $display("FAIL 8001_right[%0d]: got %h want %h", f, word_at(s0 + 32*f + 17, 1'b0), exp_r);
      end
    end
    n_tests++;
    if (req_total - r0 != 2) begin n_fail++; $display("FAIL 8001_req_count: got %0d want 2", req_total - r0); end
  endtask

  task automatic test_short_frame();
    int s0, r0;
    logic [6:0] head;
    logic [8:0] gap;
    do_reset();
    i_en = 1'b1;
    i_dac_data = 16'hFFFF;
    tick(1'b1); tick(1'b1);
    r0 = req_total;
    s0 = sidx;
    run_frame(8, 8, 16'h3C5A);
    run_frame(16, 16, 16'h3C5A);
    tick(1'b1);
    for (int i = 0; i < 7; i++) head[6-i] = dat_s[s0 + 1 + i];
    for (int i = 0; i < 9; i++) gap[8-i] = dat_s[s0 + 8 + i];
    n_tests++;
    if (head !== 7'h7F) begin n_fail++; $display("FAIL short_head: got %h want 7f", head); end
    n_tests++;
    if (gap !== 9'h000) begin n_fail++; $display("FAIL short_abort_zero: got %h want 000", gap); end
    n_tests++;
    if (busy_s[s0 + 8] !== 1'b0) begin n_fail++; $display("FAIL short_busy: got %b want 0", busy_s[s0 + 8]); end
    n_tests++;
    if (word_at(s0 + 17, 1'b0) !== 16'h3C5A) begin
      n_fail++; $display("FAIL short_restart: got %h want 3c5a", word_at(s0 + 17, 1'b0));
    end
    n_tests++;
    if (req_total - r0 != 2) begin n_fail++; $display("FAIL short_req_count: got %0d want 2", req_total - r0); end
  endtask

  task automatic test_en_drop();
    int s0, r0, ones;
    logic [5:0] head;
    do_reset();
    i_en = 1'b1;
    i_dac_data = 16'hFFFF;
    tick(1'b1); tick(1'b1);
    r0 = req_total;
    s0 = sidx;
    for (int i = 0; i < 7; i++) tick(1'b0);
    for (int i = 0; i < 6; i++) head[5-i] = dat_s[s0 + 1 + i];
    n_tests++;
    if (head !== 6'h3F) begin n_fail++; $display("FAIL endrop_head: got %h want 3f", head); end
    i_en = 1'b0;
    @(negedge i_clk);
    n_tests++;
    if (o_aud_dacdat !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL endrop_out: got dat=%b busy=%b want 0/0", o_aud_dacdat, o_busy);
    end
    n_tests++;
    if (o_dbg_state !== 3'd0) begin n_fail++; $display("FAIL endrop_state: got %0d want 0", o_dbg_state); end
    i_en = 1'b1;
    @(negedge i_clk);
    n_tests++;
    if (o_dbg_state !== 3'd1) begin n_fail++; $display("FAIL reenable_state: got %0d want 1", o_dbg_state); end
    for (int i = 0; i < 9; i++) tick(1'b0);
    for (int i = 0; i < 16; i++) tick(1'b1);
    run_frame(16, 16, 16'hFFFF);
    tick(1'b1);
    ones = 0;
    for (int i = 7; i <= 32; i++) if (dat_s[s0 + i] !== 1'b0) ones++;
    n_tests++;
    if (ones != 0) begin n_fail++; $display("FAIL reenable_silent: got %0d nonzero bits want 0", ones); end
    n_tests++;
    if (word_at(s0 + 33, 1'b0) !== 16'hFFFF) begin
      n_fail++; $display("FAIL reenable_word: got %h want ffff", word_at(s0 + 33, 1'b0));
    end
    n_tests++;
    if (req_total - r0 != 2) begin n_fail++; $display("FAIL endrop_req_count: got %0d want 2", req_total - r0); end
  endtask

  task automatic test_ramp();
    int s0, r0;
    logic [W-1:0] exp_w;
    do_reset();
    i_en = 1'b1;
    i_dac_data = '0;
    tick(1'b1); tick(1'b1);
    r0 = req_total;
    s0 = sidx;
    exp_q.delete();
    for (int n = 0; n < 100; n++) begin
      exp_q.push_back(W'(n));
      run_frame(16, 16, W'(n + 1));
    end
    tick(1'b1);
    for (int n = 0; n < 100; n++) begin
      exp_w = exp_q.pop_front();
      n_tests++;
      if (word_at(s0 + 32*n + 1, 1'b0) !== exp_w) begin
        n_fail++; $display("FAIL ramp_left[%0d]: got %h want %h", n, word_at(s0 + 32*n + 1, 1'b0), exp_w);
      end
      n_tests++;
      if (word_at(s0 + 32*n + 17, 1'b0) !== (DUP ? exp_w : '0)) begin
        n_fail++; $display("FAIL ramp_right[%0d]: got %h want %h", n, word_at(s0 + 32*n + 17, 1'b0), DUP ? exp_w : '0);
      end
    end
    n_tests++;
    if (req_total - r0 != 100) begin n_fail++; $display("FAIL ramp_req_count: got %0d want 100", req_total - r0); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_send();
    test_mono_frames();
    test_stereo_dup();
    test_short_frame();
    test_en_drop();
    test_ramp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
